// File: rtl/dvp_tx.sv
// DVP source: turns a 16-bit pixel stream into camera-style Vsync/Href/8-bit Data, high byte first.
// Optional macro DVP_TX_PATTERN_EN: underflow slots carry a {line, pixel} index pattern instead of 0x0000.
module dvp_tx #(
   parameter int H_ACTIVE   = 8,
   parameter int V_ACTIVE   = 12,
   parameter int VSYNC_LEN  = 4,
   parameter int VBP_LEN    = 10,
   parameter int HBLANK_LEN = 10
) (
   input  logic        PCLK,
   input  logic        Rst_n,
   input  logic        Enable,
   input  logic [15:0] PixelData,
   input  logic        PixelValid,
   output logic        PixelReady,
   output logic        Vsync,
   output logic        Href,
   output logic [7:0]  Data,
   output logic        FrameDone,
   output logic        Underflow,
   output logic        Busy
);

   localparam int LINE_BYTES = 2 * H_ACTIVE;
   localparam int BW   = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
   localparam int LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int TMAX = (VSYNC_LEN > VBP_LEN)
                         ? ((VSYNC_LEN > HBLANK_LEN) ? VSYNC_LEN : HBLANK_LEN)
                         : ((VBP_LEN > HBLANK_LEN) ? VBP_LEN : HBLANK_LEN);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);
   localparam logic [TW-1:0] VS_LAST   = TW'(VSYNC_LEN - 1);
   localparam logic [TW-1:0] VBP_LAST  = TW'(VBP_LEN - 1);
   localparam logic [TW-1:0] HBL_LAST  = TW'(HBLANK_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBP,
      ACTIVE,
      HBLANK
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [BW-1:0]   byte_cnt;
   logic [LW-1:0]   line_cnt;
   logic [7:0]      lo_byte;
   logic [15:0]     fill_pixel;

   // A pixel is fetched one cycle ahead of every even byte slot so its high byte lands on time.
   always_comb begin
      PixelReady = 1'b0;
      case (state)
         VBP:     PixelReady = (timer == VBP_LAST);
         ACTIVE:  PixelReady = byte_cnt[0] && (byte_cnt != BYTE_LAST);
         HBLANK:  PixelReady = (timer == HBL_LAST) && (line_cnt != LINE_LAST);
         default: PixelReady = 1'b0;
      endcase
   end

`ifdef DVP_TX_PATTERN_EN
   logic [LW-1:0] slot_line;
   logic [BW-1:0] slot_pix;

   // Index of the slot being filled: a fetch from HBLANK belongs to the next line.
   always_comb begin
      slot_line  = (state == HBLANK) ? line_cnt + LW'(1) : line_cnt;
      slot_pix   = (state == ACTIVE) ? (byte_cnt + BW'(1)) >> 1 : '0;
      fill_pixel = {8'(slot_line), 8'(slot_pix)};
   end
`else
   assign fill_pixel = 16'h0000;
`endif

   // NOTE: state, counters and outputs all update with non-blocking assignments so every
   // read in this block sees the pre-edge value, regardless of statement order.
   always_ff @(posedge PCLK or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         byte_cnt  <= '0;
         line_cnt  <= '0;
         // NOTE: the low-byte holding register is reset too, so the first line after
         // reset never shows stale data even if the fetch logic changes later.
         lo_byte   <= '0;
         Vsync     <= 1'b0;
         Href      <= 1'b0;
         Data      <= 8'h00;
         FrameDone <= 1'b0;
         Underflow <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         FrameDone <= 1'b0;

         if (PixelReady) begin
            Data    <= PixelValid ? PixelData[15:8] : fill_pixel[15:8];
            lo_byte <= PixelValid ? PixelData[7:0]  : fill_pixel[7:0];
            if (!PixelValid)
               Underflow <= 1'b1;
         end else if (state == ACTIVE && !byte_cnt[0]) begin
            Data <= lo_byte;
         end else begin
            Data <= 8'h00;
         end

         case (state)
            IDLE: begin
               if (Enable) begin
                  state     <= VSYNC;
                  Vsync     <= 1'b1;
                  Busy      <= 1'b1;
                  timer     <= '0;
                  line_cnt  <= '0;
                  Underflow <= 1'b0;
               end
            end

            VSYNC: begin
               if (timer == VS_LAST) begin
                  state <= VBP;
                  Vsync <= 1'b0;
                  timer <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            VBP: begin
               if (timer == VBP_LAST) begin
                  state    <= ACTIVE;
                  Href     <= 1'b1;
                  timer    <= '0;
                  byte_cnt <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            ACTIVE: begin
               if (byte_cnt == BYTE_LAST) begin
                  state    <= HBLANK;
                  Href     <= 1'b0;
                  byte_cnt <= '0;
                  timer    <= '0;
                  if (line_cnt == LINE_LAST)
                     FrameDone <= 1'b1;
               end else begin
                  byte_cnt <= byte_cnt + BW'(1);
               end
            end

            HBLANK: begin
               if (timer == HBL_LAST) begin
                  timer <= '0;
                  if (line_cnt != LINE_LAST) begin
                     state    <= ACTIVE;
                     Href     <= 1'b1;
                     line_cnt <= line_cnt + LW'(1);
                  end else if (Enable) begin
                     state     <= VSYNC;
                     Vsync     <= 1'b1;
                     line_cnt  <= '0;
                     Underflow <= 1'b0;
                  end else begin
                     state <= IDLE;
                     Busy  <= 1'b0;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            default: begin
               state <= IDLE;
               Vsync <= 1'b0;
               Href  <= 1'b0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dvp_tx.sv
// Directed bench for dvp_tx: frame timing, byte order, pixel handshake, underflow fill,
// mid-frame reset and Enable drop, with a behavioural DVP capture model for loopback.
module tb_dvp_tx;

   localparam int H     = 8;
   localparam int V     = 12;
   localparam int VS    = 4;
   localparam int VBP   = 10;
   localparam int HB    = 10;
   localparam int FRAME = 326;

   logic        PCLK = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Enable = 1'b0;
   logic [15:0] PixelData = 16'h0000;
   logic        PixelValid = 1'b1;
   logic        PixelReady, Vsync, Href, FrameDone, Underflow, Busy;
   logic [7:0]  Data;

   always #5 PCLK = ~PCLK;

   dvp_tx #(
      .H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_LEN(VS), .VBP_LEN(VBP), .HBLANK_LEN(HB)
   ) dut (
      .PCLK(PCLK), .Rst_n(Rst_n), .Enable(Enable),
      .PixelData(PixelData), .PixelValid(PixelValid), .PixelReady(PixelReady),
      .Vsync(Vsync), .Href(Href), .Data(Data),
      .FrameDone(FrameDone), .Underflow(Underflow), .Busy(Busy)
   );

   int n_pass  = 0;
   int n_total = 0;

   int          cyc, src_val, frame_slot, drop_slot, accepted, idle_data_bad;
   bit          pend;
   logic        prev_vs, prev_href;
   int          vs_rise_q[$], vs_fall_q[$], href_rise_q[$], href_fall_q[$], fd_q[$], acc_at_rise[$];
   logic        uf_at_rise[$], uf_at_fd[$];
   logic [7:0]  byte_q[$];
   logic [15:0] exp_q[$];

   function automatic logic [15:0] fill_model(input int slot);
`ifdef DVP_TX_PATTERN_EN
      return {8'(slot / H), 8'(slot % H)};
`else
      return 16'h0000;
`endif
   endfunction

   task automatic clear_stats();
      vs_rise_q.delete(); vs_fall_q.delete(); href_rise_q.delete(); href_fall_q.delete();
      fd_q.delete(); acc_at_rise.delete(); uf_at_rise.delete(); uf_at_fd.delete();
      byte_q.delete(); exp_q.delete();
      cyc = 0; src_val = 1; PixelData = 16'd1; PixelValid = 1'b1; pend = 1'b0;
      frame_slot = 0; drop_slot = -1; accepted = 0; idle_data_bad = 0;
      prev_vs = Vsync; prev_href = Href;
   endtask

   // One PCLK cycle: advance the source, monitor outputs at the falling edge, answer PixelReady.
   task automatic step();
      @(negedge PCLK);
      cyc++;
      if (pend) begin
         accepted++;
         src_val++;
         PixelData = 16'(src_val);
         pend = 1'b0;
      end
      if (Vsync && !prev_vs) begin
         vs_rise_q.push_back(cyc);
         acc_at_rise.push_back(accepted);
         uf_at_rise.push_back(Underflow);
         frame_slot = 0;
      end
      if (!Vsync && prev_vs) vs_fall_q.push_back(cyc);
      if (Href && !prev_href) href_rise_q.push_back(cyc);
      if (!Href && prev_href) href_fall_q.push_back(cyc);
      if (Href) byte_q.push_back(Data);
      else if (Data !== 8'h00) idle_data_bad++;
      if (FrameDone) begin
         fd_q.push_back(cyc);
         uf_at_fd.push_back(Underflow);
      end
      prev_vs = Vsync;
      prev_href = Href;
      if (PixelReady) begin
         PixelValid = !(vs_rise_q.size() == 1 && frame_slot == drop_slot);
         exp_q.push_back(PixelValid ? PixelData : fill_model(frame_slot));
         pend = PixelValid;
         frame_slot++;
      end else begin
         PixelValid = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (!Busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Capture-side model: pair bytes into pixels and compare against what the source offered.
   function automatic int loop_errs();
      int errs = 0;
      for (int i = 0; i < exp_q.size() && 2 * i + 1 < byte_q.size(); i++)
         if ({byte_q[2*i], byte_q[2*i+1]} !== exp_q[i]) errs++;
      return errs;
   endfunction

   function automatic int href_shape_errs();
      int errs = 0;
      for (int i = 0; i < href_rise_q.size() && i < href_fall_q.size(); i++) begin
         if (href_fall_q[i] - href_rise_q[i] != 2 * H) errs++;
         if (i + 1 < href_rise_q.size() && href_rise_q[i+1] - href_fall_q[i] != HB) errs++;
      end
      return errs;
   endfunction

   task automatic test_reset();
      bit ok;
      Rst_n = 1'b0; Enable = 1'b1; PixelValid = 1'b1;
      repeat (3) @(negedge PCLK);
      n_total++; if ({Vsync, Href} !== 2'b00) $display("FAIL reset_sync: got %b expected 00", {Vsync, Href}); else n_pass++;
      n_total++; if (Data !== 8'h00) $display("FAIL reset_data: got %h expected 00", Data); else n_pass++;
      n_total++; if ({PixelReady, FrameDone, Underflow, Busy} !== 4'b0000) $display("FAIL reset_status: got %b expected 0000", {PixelReady, FrameDone, Underflow, Busy}); else n_pass++;
      Enable = 1'b0;
      Rst_n = 1'b1;
      clear_stats();
      step();
      n_total++; if (Busy !== 1'b0) $display("FAIL idle_hold: Busy got %b expected 0", Busy); else n_pass++;
      ok = 1'b1;
   endtask

   task automatic test_single_frame();
      bit ok;
      int derr;
      clear_stats();
      Enable = 1'b1;
      step();
      Enable = 1'b0;
      wait_idle(FRAME + 20, ok);
      n_total++; if (!ok) $display("FAIL single_idle: timeout got busy expected idle"); else n_pass++;
      n_total++; if (vs_rise_q.size() != 1 || vs_fall_q.size() != 1) $display("FAIL single_vs_count: got %0d rises expected 1", vs_rise_q.size()); else n_pass++;
      n_total++; if (vs_fall_q.size() < 1 || vs_fall_q[0] - vs_rise_q[0] != VS) $display("FAIL single_vs_width: got %0d expected %0d", (vs_fall_q.size() > 0) ? vs_fall_q[0] - vs_rise_q[0] : -1, VS); else n_pass++;
      n_total++; if (href_rise_q.size() < 1 || vs_fall_q.size() < 1 || href_rise_q[0] - vs_fall_q[0] != VBP) $display("FAIL single_vbp: got %0d expected %0d", (href_rise_q.size() > 0 && vs_fall_q.size() > 0) ? href_rise_q[0] - vs_fall_q[0] : -1, VBP); else n_pass++;
      n_total++; if (href_rise_q.size() != V) $display("FAIL single_lines: got %0d expected %0d", href_rise_q.size(), V); else n_pass++;
      n_total++; if (href_shape_errs() != 0) $display("FAIL single_href_shape: got %0d bad widths/gaps expected 0", href_shape_errs()); else n_pass++;
      n_total++; if (byte_q.size() != 2 * H * V) $display("FAIL single_bytes: got %0d expected %0d", byte_q.size(), 2 * H * V); else n_pass++;
      derr = 0;
      for (int p = 0; p < H * V && 2 * p + 1 < byte_q.size(); p++)
         if (byte_q[2*p] !== 8'h00 || byte_q[2*p+1] !== 8'(p + 1)) derr++;
      n_total++; if (derr != 0) $display("FAIL single_data: got %0d wrong pixels expected 0", derr); else n_pass++;
      n_total++; if (loop_errs() != 0 || exp_q.size() != H * V) $display("FAIL single_loopback: got %0d errors over %0d pixels expected 0 over %0d", loop_errs(), exp_q.size(), H * V); else n_pass++;
      n_total++; if (fd_q.size() != 1 || href_fall_q.size() != V || fd_q[0] != href_fall_q[V-1]) $display("FAIL single_framedone: got %0d pulses expected 1 at last Href fall", fd_q.size()); else n_pass++;
      n_total++; if (idle_data_bad != 0) $display("FAIL single_idle_data: got %0d nonzero bytes with Href low expected 0", idle_data_bad); else n_pass++;
      n_total++; if (Underflow !== 1'b0) $display("FAIL single_underflow: got %b expected 0", Underflow); else n_pass++;
   endtask

   task automatic test_continuous();
      bit ok;
      clear_stats();
      Enable = 1'b1;
      for (int i = 0; i < 3 * FRAME + 50 && vs_rise_q.size() < 3; i++) step();
      Enable = 1'b0;
      n_total++; if (vs_rise_q.size() != 3) $display("FAIL cont_rises: got %0d expected 3", vs_rise_q.size()); else n_pass++;
      if (vs_rise_q.size() == 3) begin
         n_total++; if (vs_rise_q[1] - vs_rise_q[0] != FRAME || vs_rise_q[2] - vs_rise_q[1] != FRAME) $display("FAIL cont_period: got %0d,%0d expected %0d", vs_rise_q[1] - vs_rise_q[0], vs_rise_q[2] - vs_rise_q[1], FRAME); else n_pass++;
         n_total++; if (acc_at_rise[1] - acc_at_rise[0] != H * V || acc_at_rise[2] - acc_at_rise[1] != H * V) $display("FAIL cont_accepted: got %0d,%0d expected %0d", acc_at_rise[1] - acc_at_rise[0], acc_at_rise[2] - acc_at_rise[1], H * V); else n_pass++;
      end
      wait_idle(FRAME + 20, ok);
      n_total++; if (!ok) $display("FAIL cont_idle: timeout got busy expected idle"); else n_pass++;
      n_total++; if (loop_errs() != 0 || byte_q.size() != 2 * exp_q.size() || exp_q.size() != 3 * H * V) $display("FAIL cont_loopback: got %0d errors over %0d pixels expected 0 over %0d", loop_errs(), exp_q.size(), 3 * H * V); else n_pass++;
   endtask

   task automatic test_underflow();
      bit ok;
      logic [7:0] exp_lo;
`ifdef DVP_TX_PATTERN_EN
      exp_lo = 8'h05;
`else
      exp_lo = 8'h00;
`endif
      clear_stats();
      drop_slot = 5;
      Enable = 1'b1;
      for (int i = 0; i < 2 * FRAME + 20 && vs_rise_q.size() < 2; i++) step();
      Enable = 1'b0;
      wait_idle(FRAME + 20, ok);
      n_total++; if (!ok || vs_rise_q.size() != 2) $display("FAIL uf_frames: got %0d frames expected 2", vs_rise_q.size()); else n_pass++;
      n_total++; if (byte_q.size() < 14 || byte_q[10] !== 8'h00 || byte_q[11] !== exp_lo) $display("FAIL uf_fill: got %h%h expected 00%h", (byte_q.size() > 10) ? byte_q[10] : 8'hxx, (byte_q.size() > 11) ? byte_q[11] : 8'hxx, exp_lo); else n_pass++;
      n_total++; if (byte_q.size() < 14 || byte_q[9] !== 8'h05 || byte_q[13] !== 8'h06) $display("FAIL uf_neighbours: got %h,%h expected 05,06", (byte_q.size() > 9) ? byte_q[9] : 8'hxx, (byte_q.size() > 13) ? byte_q[13] : 8'hxx); else n_pass++;
      n_total++; if (uf_at_fd.size() < 1 || uf_at_fd[0] !== 1'b1) $display("FAIL uf_set: got %b expected 1", (uf_at_fd.size() > 0) ? uf_at_fd[0] : 1'bx); else n_pass++;
      n_total++; if (uf_at_rise.size() != 2 || uf_at_rise[0] !== 1'b0 || uf_at_rise[1] !== 1'b0) $display("FAIL uf_clear_at_vsync: got %0d samples expected two zeros", uf_at_rise.size()); else n_pass++;
      n_total++; if (Underflow !== 1'b0) $display("FAIL uf_final: got %b expected 0", Underflow); else n_pass++;
      n_total++; if (loop_errs() != 0) $display("FAIL uf_loopback: got %0d errors expected 0", loop_errs()); else n_pass++;
   endtask

   task automatic test_mid_reset();
      bit ok;
      clear_stats();
      Enable = 1'b1;
      for (int i = 0; i < FRAME && href_rise_q.size() < 4; i++) step();
      repeat (5) step();
      n_total++; if (Href !== 1'b1) $display("FAIL mrst_in_line: Href got %b expected 1", Href); else n_pass++;
      #1 Rst_n = 1'b0;
      #1;
      n_total++; if ({Vsync, Href, Data, Busy} !== 11'd0) $display("FAIL mrst_async: got %b expected all zero", {Vsync, Href, Data, Busy}); else n_pass++;
      repeat (2) @(negedge PCLK);
      Rst_n = 1'b1;
      clear_stats();
      step();
      n_total++; if (Vsync !== 1'b1 || vs_rise_q.size() != 1) $display("FAIL mrst_restart: Vsync got %b expected 1", Vsync); else n_pass++;
      Enable = 1'b0;
      wait_idle(FRAME + 20, ok);
      n_total++; if (!ok || loop_errs() != 0) $display("FAIL mrst_frame: got idle=%0d errors=%0d expected 1,0", ok, loop_errs()); else n_pass++;
   endtask

   task automatic test_enable_drop();
      bit ok;
      clear_stats();
      Enable = 1'b1;
      for (int i = 0; i < FRAME && href_rise_q.size() < 7; i++) step();
      repeat (3) step();
      Enable = 1'b0;
      wait_idle(FRAME, ok);
      n_total++; if (!ok) $display("FAIL drop_idle: timeout got busy expected idle"); else n_pass++;
      n_total++; if (fd_q.size() != 1 || href_rise_q.size() != V) $display("FAIL drop_complete: got %0d FrameDone, %0d lines expected 1, %0d", fd_q.size(), href_rise_q.size(), V); else n_pass++;
      n_total++; if (loop_errs() != 0 || byte_q.size() != 2 * H * V) $display("FAIL drop_loopback: got %0d errors, %0d bytes expected 0, %0d", loop_errs(), byte_q.size(), 2 * H * V); else n_pass++;
      repeat (40) step();
      n_total++; if (vs_rise_q.size() != 1 || Busy !== 1'b0) $display("FAIL drop_no_vsync: got %0d rises busy=%b expected 1,0", vs_rise_q.size(), Busy); else n_pass++;
      Enable = 1'b1;
      step();
      n_total++; if ({Vsync, Busy} !== 2'b11) $display("FAIL drop_restart: got %b expected 11", {Vsync, Busy}); else n_pass++;
      Enable = 1'b0;
      wait_idle(FRAME + 20, ok);
      n_total++; if (!ok) $display("FAIL drop_restart_idle: timeout got busy expected idle"); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_continuous();
      test_underflow();
      test_mid_reset();
      test_enable_drop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
